imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 201 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: turns a length-prefixed byte stream into word writes with byte strobes.
// Defining IMEM_LOADER_CKSUM_EN adds a trailing XOR checksum byte after the payload.
module imem_loader #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           LAU        = 8,
  parameter int unsigned           SIZE_LAU   = 32'd1048576,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [3:0]            wstrb_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4,
    CKSUM = 3'd5
  } state_t;
  localparam state_t PAYLOAD_END = CKSUM;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;
  localparam state_t PAYLOAD_END = DONE;
`endif

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [31:0]           len;
  logic [31:0]           len_full;
  logic [DATA_WIDTH-1:0] wbuf, wbuf_next;
  logic [3:0]            strb, strb_next;
  logic                  accept;
  logic                  lane_last;
  logic                  pay_last;
  logic                  oversize;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]            xsum;
`endif

  function automatic logic [DATA_WIDTH-1:0] lane_insert(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            lane,
    input logic [7:0]            value
  );
    logic [DATA_WIDTH-1:0] res;
    res = word;
    res[lane*LAU +: 8] = value;
    return res;
  endfunction

  // Ready depends on the state alone so the source never sees a valid->ready loop.
  always_comb begin
    rx_ready_o = 1'b0;
    case (state)
      LEN, DATA: rx_ready_o = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
      CKSUM:     rx_ready_o = 1'b1;
`endif
      default:   rx_ready_o = 1'b0;
    endcase
  end

  assign accept    = rx_valid_i & rx_ready_o;
  assign lane_last = (cnt[1:0] == 2'b11);
  // Length bytes arrive LSB first, so shifting in from the top leaves N in place.
  assign len_full  = {rx_data_i, len[31:8]};
  assign oversize  = (len_full > SIZE_LAU);
  assign pay_last  = (64'(cnt) == (64'(len) - 64'd1));
  assign wbuf_next = lane_insert(wbuf, cnt[1:0], rx_data_i);
  assign strb_next = strb | (4'b0001 << cnt[1:0]);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start_i) state_next = LEN;
        else         state_next = state;
      end
      LEN: begin
        if (accept && lane_last) begin
          if (len_full == 32'd0) state_next = PAYLOAD_END;
          else if (oversize)     state_next = ERR;
          else                   state_next = DATA;
        end else begin
          state_next = state;
        end
      end
      DATA: begin
        if (accept && pay_last) state_next = PAYLOAD_END;
        else                    state_next = state;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      CKSUM: begin
        if (accept) state_next = (rx_data_i == xsum) ? DONE : ERR;
        else        state_next = state;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Datapath: length capture, word packing, write port and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      len     <= 32'd0;
      wbuf    <= '0;
      strb    <= 4'b0000;
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
      wstrb_o <= 4'b0000;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      xsum    <= 8'h00;
`endif
    end else begin
      we_o   <= 1'b0;
      done_o <= (state_next == DONE);
      err_o  <= (state_next == ERR);
`ifdef IMEM_LOADER_CKSUM_EN
      busy_o <= (state_next == LEN) || (state_next == DATA) || (state_next == CKSUM);
`else
      busy_o <= (state_next == LEN) || (state_next == DATA);
`endif
      case (state)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            cnt  <= '0;
            len  <= 32'd0;
            wbuf <= '0;
            strb <= 4'b0000;
`ifdef IMEM_LOADER_CKSUM_EN
            xsum <= 8'h00;
`endif
          end
        end
        LEN: begin
          if (accept) begin
            len <= len_full;
            cnt <= lane_last ? '0 : cnt + ADDR_WIDTH'(1'b1);
          end
        end
        DATA: begin
          if (accept) begin
            cnt <= cnt + ADDR_WIDTH'(1'b1);
`ifdef IMEM_LOADER_CKSUM_EN
            xsum <= xsum ^ rx_data_i;
`endif
            if (lane_last || pay_last) begin
              we_o    <= 1'b1;
              waddr_o <= BASE_ADDR + {cnt[ADDR_WIDTH-1:2], 2'b00};
              wdata_o <= wbuf_next;
              wstrb_o <= strb_next;
              wbuf    <= '0;
              strb    <= 4'b0000;
            end else begin
              wbuf <= wbuf_next;
              strb <= strb_next;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames
// compared against a word-packing model built from the frame definition.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned SIZE = 32'd1048576;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        dn;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, we, busy, done, err;
  logic [31:0] waddr, wdata;
  logic [3:0]  wstrb;

  int  tests = 0;
  int  fails = 0;
  wr_t obs_q[$];

  imem_loader #(.BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .rx_valid_i(rx_valid),
    .rx_data_i(rx_data), .rx_ready_o(rx_ready), .we_o(we), .waddr_o(waddr),
    .wdata_o(wdata), .wstrb_o(wstrb), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  // Capture every write strobe together with done at that instant.
  always @(negedge clk) begin
    if (we === 1'b1) obs_q.push_back({waddr, wdata, wstrb, done});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_gap(input int g);
    return (g < 0) ? int'($urandom_range(0, 2)) : g;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "/we"}, we, 64'd0);
    chk({tag, "/waddr"}, waddr, 64'd0);
    chk({tag, "/wdata"}, wdata, 64'd0);
    chk({tag, "/wstrb"}, wstrb, 64'd0);
    chk({tag, "/flags"}, {busy, done, err, rx_ready}, 64'd0);
  endtask

  // Model: byte i of the payload belongs to word i/4, lane i%4.
  task automatic check_writes(input string tag, input byte_q_t pl);
    int nw;
    logic [31:0] d;
    logic [3:0]  s;
    nw = (pl.size() + 3) / 4;
    chk({tag, "/nwrites"}, obs_q.size(), nw);
    for (int w = 0; w < nw && w < obs_q.size(); w++) begin
      d = 32'd0;
      s = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < pl.size()) begin
          d[8*k +: 8] = pl[4*w + k];
          s[k] = 1'b1;
        end
      end
      chk($sformatf("%s/addr%0d", tag, w), obs_q[w].a, BASE + 32'(4 * w));
      chk($sformatf("%s/data%0d", tag, w), obs_q[w].d, d);
      chk($sformatf("%s/strb%0d", tag, w), obs_q[w].s, s);
    end
  endtask

  task automatic run_frame(input string tag, input byte_q_t pl, input int gap,
                           input bit do_start, input bit bad_ck);
    logic [31:0] n;
    logic [7:0]  x;
    bit          ok;
    n  = pl.size();
    x  = 8'h00;
    ok = 1'b1;
    obs_q.delete();
    if (do_start) pulse_start();
    for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], pick_gap(gap));
    foreach (pl[i]) begin
      send_byte(pl[i], pick_gap(gap));
      x ^= pl[i];
    end
`ifdef IMEM_LOADER_CKSUM_EN
    chk({tag, "/we_last"}, we, (n != 32'd0));
    chk({tag, "/done_before_ck"}, done, 64'd0);
    ok = !bad_ck;
    send_byte(bad_ck ? (x ^ 8'h5a) : x, pick_gap(gap));
    chk({tag, "/err_now"}, err, !ok);
`else
    chk({tag, "/we_last"}, we, (n != 32'd0));
    chk({tag, "/bad_ck_unused"}, bad_ck, 64'd0);
`endif
    chk({tag, "/done_now"}, done, ok);
    repeat (2) @(negedge clk);
    check_writes(tag, pl);
    chk({tag, "/end_flags"}, {busy, done, err, rx_ready}, {1'b0, ok, !ok, 1'b0});
  endtask

  initial begin
    byte_q_t     pl;
    logic [31:0] big;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    pl = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_frame("aligned", pl, 0, 1'b1, 1'b0);
    chk("aligned/w1_data", obs_q.size() > 1 ? obs_q[1].d : 32'hx, 32'h0010_0093);
    chk("aligned/w1_done", obs_q.size() > 1 ? obs_q[1].dn : 1'bx, 1'b1);

    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_frame("partial", pl, 0, 1'b1, 1'b0);
    chk("partial/w1", obs_q.size() > 1 ? {obs_q[1].d, 28'd0, obs_q[1].s} : 64'hx,
        {32'h0000_0605, 28'd0, 4'b0011});

    pl = {};
    run_frame("n0", pl, 0, 1'b1, 1'b0);

    obs_q.delete();
    pulse_start();
    big = SIZE + 32'd1;
    for (int k = 0; k < 4; k++) send_byte(big[8*k +: 8], 0);
    chk("oversize/flags", {busy, done, err, rx_ready}, 64'b0010);
    repeat (3) @(negedge clk);
    chk("oversize/nwrites", obs_q.size(), 64'd0);
    pulse_start();
    chk("oversize/restart", {busy, err, rx_ready}, 64'b101);
    pl = '{8'hde, 8'had, 8'hbe, 8'hef, 8'h42};
    run_frame("after_err", pl, 0, 1'b0, 1'b0);

    pl = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_frame("throttled", pl, 2, 1'b1, 1'b0);

    obs_q.delete();
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte((k == 0) ? 8'd8 : 8'd0, 0);
    for (int k = 0; k < 3; k++) send_byte(8'h70 + 8'(k), 0);
    pulse_reset();
    check_idle_outputs("midreset");
    chk("midreset/nwrites", obs_q.size(), 64'd0);
    pulse_start();
    chk("midreset/restart", {busy, rx_ready}, 64'b11);
    run_frame("post_reset", pl, 0, 1'b0, 1'b0);

    for (int f = 0; f < 8; f++) begin
      pl = {};
      for (int i = 0; i < int'($urandom_range(1, 14)); i++) pl.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", f), pl, -1, 1'b1, 1'b0);
    end

`ifdef IMEM_LOADER_CKSUM_EN
    pl = '{8'haa, 8'h55};
    run_frame("ck_good", pl, 0, 1'b1, 1'b0);
    chk("ck_good/w0", obs_q.size() > 0 ? obs_q[0].d : 32'hx, 32'h0000_55aa);
    run_frame("ck_bad", pl, 0, 1'b1, 1'b1);
    chk("ck_bad/w0", obs_q.size() > 0 ? obs_q[0].d : 32'hx, 32'h0000_55aa);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
